// File: rtl/posit_result_align.sv
// Result aligner for the posit product-sum pipeline: valid delay line, credit-based issue control and in-order result FIFO.
// Optional NaR/zero/truncation push counters are enabled by defining POSIT_RESULT_STATS_EN.
module posit_result_align #(
  parameter int unsigned N       = 32,
  parameter int unsigned LATENCY = 12,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [N-1:0]             pipe_result,
  input  logic                     pipe_truncated,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic                     out_truncated,
  output logic [$clog2(DEPTH):0]   in_flight
`ifdef POSIT_RESULT_STATS_EN
  ,
  output logic [31:0]              stat_nar,
  output logic [31:0]              stat_zero,
  output logic [31:0]              stat_trunc
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [LATENCY-1:0] r_vld;
  logic [CW-1:0]      r_in_flight;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic               r_run;
  logic [N:0]         r_mem [DEPTH];

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [CW:0]        w_credit;
  logic [N:0]         w_head;

  // Credits cover both buffered and still-travelling results, so a push can never meet a full FIFO.
  assign w_credit    = {1'b0, r_count} + {1'b0, r_in_flight};
  assign issue_ready = r_run && (w_credit < (CW+1)'(DEPTH));
  assign w_accept    = issue_valid && issue_ready;
  assign w_push      = r_vld[LATENCY-1];
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_head      = r_mem[r_rptr];
  assign out_data    = w_head[N-1:0];
  assign out_truncated = w_head[N];
  assign in_flight   = r_in_flight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_in_flight <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_run <= 1'b1;
      case ({w_accept, w_push})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  // Storage is deliberately not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {pipe_truncated, pipe_result};
  end

`ifdef POSIT_RESULT_STATS_EN
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_nar   <= '0;
      stat_zero  <= '0;
      stat_trunc <= '0;
    end else if (w_push) begin
      if (pipe_result == NAR && stat_nar != '1)     stat_nar   <= stat_nar + 32'd1;
      if (pipe_result == '0 && stat_zero != '1)     stat_zero  <= stat_zero + 32'd1;
      if (pipe_truncated && stat_trunc != '1)       stat_trunc <= stat_trunc + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) w_push |-> (r_count < CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_posit_result_align.sv
// Bench for posit_result_align: phase table with checkpoints plus a per-cycle scoreboard of issued results.
module tb_posit_result_align;

  localparam int N = 32;
  localparam int L = 12;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [N-1:0]  pipe_result;
  logic          pipe_truncated;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_truncated;
  logic [4:0]    in_flight;
`ifdef POSIT_RESULT_STATS_EN
  logic [31:0]   stat_nar, stat_zero, stat_trunc;
`endif

  posit_result_align #(.N(N), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pipe_result(pipe_result), .pipe_truncated(pipe_truncated), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_truncated(out_truncated),
    .in_flight(in_flight)
`ifdef POSIT_RESULT_STATS_EN
    , .stat_nar(stat_nar), .stat_zero(stat_zero), .stat_trunc(stat_trunc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    bit iv;
    bit ordy;
    int exp_if;
    int exp_vld;
    int exp_rdy;
  } row_t;

  row_t         rows[11];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = -1;
  bit [L-1:0]   m_vld;
  int           m_if, m_cnt;
  bit           m_rdy, m_started;
  bit           prev_acc, prev_pop;
  logic [N:0]   prev_word;
  logic [N:0]   tb_pipe[L];
  logic [N:0]   exp_q[$];
  bit           track;
  int           first_pop, last_pop, gaps, n_popped;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_vld = '0; m_if = 0; m_cnt = 0; m_started = 0;
    prev_acc = 0; prev_pop = 0;
    exp_q.delete();
  endtask

  // One cycle: advance model, drive inputs, sample outputs after the falling edge.
  task automatic step(input bit iv, input bit ordy, input logic [N-1:0] d, input bit tr);
    bit ex;
    @(negedge clk);
    cyc++;
    m_started = 1;
    ex = m_vld[L-1];
    m_vld = {m_vld[L-2:0], prev_acc};
    m_if  = m_if + int'(prev_acc) - int'(ex);
    m_cnt = m_cnt + int'(ex) - int'(prev_pop);
    for (int i = L-1; i > 0; i--) tb_pipe[i] = tb_pipe[i-1];
    tb_pipe[0] = prev_word;
    {pipe_truncated, pipe_result} = tb_pipe[L-1];
    issue_valid = iv;
    out_ready = ordy;
    #1;
    m_rdy = m_started && (m_cnt + m_if < D);
    chk("issue_ready", 64'(issue_ready), 64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
    chk("in_flight", 64'(in_flight), 64'(m_if));
    if (m_cnt != 0) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      else chk("head_word", 64'({out_truncated, out_data}), 64'(exp_q[0]));
    end
    prev_acc  = iv && m_rdy;
    prev_word = {tr, d};
    if (prev_acc) exp_q.push_back({tr, d});
    prev_pop = ordy && (m_cnt != 0);
    if (prev_pop) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (track) begin
        n_popped++;
        if (first_pop < 0) first_pop = cyc;
        else if (cyc - last_pop != 1) gaps++;
        last_pop = cyc;
      end
    end
  endtask

  task automatic rstep(input bit iv, input bit ordy);
    step(iv, ordy, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_flight", 64'(in_flight), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc, n_acc, guard;
    rows[0]  = '{1,  1, 0,  0, 0, 1};
    rows[1]  = '{12, 0, 0,  1, 0, 1};
    rows[2]  = '{1,  0, 0,  0, 1, 1};
    rows[3]  = '{1,  0, 1,  0, 1, 1};
    rows[4]  = '{1,  0, 0,  0, 0, 1};
    rows[5]  = '{40, 1, 0,  0, 1, 0};
    rows[6]  = '{20, 0, 1,  0, 0, 1};
    rows[7]  = '{17, 1, 0, 12, 1, 0};
    rows[8]  = '{12, 1, 1, 10, 1, 1};
    rows[9]  = '{40, 1, 1, -1, -1, -1};
    rows[10] = '{30, 0, 1,  0, 0, 1};

    for (int i = 0; i < L; i++) tb_pipe[i] = '0;
    prev_word = '0;
    track = 0; first_pop = -1; last_pop = 0; gaps = 0; n_popped = 0;
    issue_valid = 0; out_ready = 0; pipe_result = '0; pipe_truncated = 0;
    reset = 1'b0;
    #1;
    do_reset();

    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < rows[r].cycles; k++) rstep(rows[r].iv, rows[r].ordy);
      if (rows[r].exp_if >= 0)  chk($sformatf("row%0d_in_flight", r), 64'(in_flight), 64'(rows[r].exp_if));
      if (rows[r].exp_vld >= 0) chk($sformatf("row%0d_out_valid", r), 64'(out_valid), 64'(rows[r].exp_vld));
      if (rows[r].exp_rdy >= 0) chk($sformatf("row%0d_issue_ready", r), 64'(issue_ready), 64'(rows[r].exp_rdy));
    end

    // Full-rate stream of 1000 results from an idle block.
    track = 1; n_acc = 0; guard = 0; acc_cyc = -1;
    while (n_acc < 1000 && guard < 3000) begin
      rstep(1, 1);
      guard++;
      if (prev_acc) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        n_acc++;
      end
    end
    chk("stream_issue_cycles", 64'(guard), 64'd1000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      rstep(0, 1);
      guard++;
    end
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_pops", 64'(n_popped), 64'd1000);
    chk("stream_latency", 64'(first_pop - acc_cyc), 64'd13);
    chk("stream_gaps", 64'(gaps), 64'd0);
    track = 0;
    repeat (3) rstep(0, 1);

    // Reset with four buffered and three still in flight.
    repeat (4) rstep(1, 0);
    repeat (12) rstep(0, 0);
    repeat (3) rstep(1, 0);
    repeat (2) rstep(0, 0);
    chk("pre_reset_in_flight", 64'(in_flight), 64'd3);
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2;
    do_reset();
    repeat (16) rstep(0, 1);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_in_flight", 64'(in_flight), 64'd0);

    // NaR, zero and truncated pushes.
    step(1, 0, 32'h8000_0000, 1'b0);
    step(1, 0, 32'h0000_0000, 1'b0);
    step(1, 0, 32'h1234_5678, 1'b1);
    repeat (20) rstep(0, 1);
    chk("special_drained", 64'(exp_q.size()), 64'd0);
`ifdef POSIT_RESULT_STATS_EN
    chk("stat_nar", 64'(stat_nar), 64'd1);
    chk("stat_zero", 64'(stat_zero), 64'd1);
    chk("stat_trunc", 64'(stat_trunc), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_result_align.md
POSIT_RESULT_ALIGN -- requirements
Module: posit_result_align

Interface
REQ-001 Parameter N, default 32, posit width of the normalized result word.
REQ-002 Parameter LATENCY, default 12, cycles from issue to valid result at the normalize_prod_sum output.
REQ-003 Parameter DEPTH, default 16, result FIFO entries; power of two, at least 2.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high; clears all state.
REQ-006 Port issue_valid, input, 1, upstream presents an operand set to the product-sum pipeline this cycle.
REQ-007 Port issue_ready, output, 1, high when an issue is accepted this cycle; the pipeline start qualifier is issue_valid AND issue_ready.
REQ-008 Port pipe_result, input, N, normalized posit sum-of-products from the pipeline.
REQ-009 Port pipe_truncated, input, 1, truncation flag travelling with pipe_result.
REQ-010 Port out_valid, output, 1, FIFO head holds a result.
REQ-011 Port out_ready, input, 1, consumer accepts the head this cycle.
REQ-012 Port out_data, output, N, FIFO head posit.
REQ-013 Port out_truncated, output, 1, FIFO head truncation flag.
REQ-014 Port in_flight, output, log2(DEPTH)+1, count of results issued but not yet written to the FIFO.

Function
REQ-015 Issue acceptance: an issue is accepted when issue_valid=1 and issue_ready=1 in the same cycle.
REQ-016 The block SHALL hold a LATENCY-stage valid delay line that shifts every cycle; stage 0 loads 1 on an accepted issue and 0 otherwise.
REQ-017 When the last delay stage is 1, the block SHALL write {pipe_truncated, pipe_result} into the FIFO in that cycle. The pipeline has no stall, so this write is never refused.
REQ-018 Credit rule: issue_ready = (fifo_count + in_flight) < DEPTH, computed combinationally from registered state only. This guarantees that no write of REQ-017 can meet a full FIFO.
REQ-019 in_flight counts up by 1 on an accepted issue and down by 1 on a delay-line exit. When both happen in the same cycle it is unchanged.
REQ-020 FIFO: circular buffer with read and write pointers wrapping modulo DEPTH. out_valid = (fifo_count != 0). out_data and out_truncated show the head entry combinationally from storage.
REQ-021 A pop occurs when out_valid=1 and out_ready=1. When a push and a pop happen in the same cycle, fifo_count is unchanged and both pointers advance.
REQ-022 When out_ready=1 while the FIFO is empty, nothing happens. A push into an empty FIFO becomes visible on out_valid in the next cycle; there is no fall-through.
REQ-023 Results SHALL leave in strict issue order, with no loss and no duplication.
REQ-024 An internal overflow (write while full) is a design error. It SHALL raise an assertion in simulation builds.

Reset
REQ-025 While reset=1, asynchronously: the delay line is 0, in_flight=0, fifo_count=0, both pointers are 0, out_valid=0, and issue_ready=0.
REQ-026 On the first rising edge after reset deasserts, issue_ready=1. FIFO storage contents are not reset.
REQ-027 A reset in the middle of operation discards all in-flight and buffered results. Pipeline outputs arriving after reset are ignored because the delay line is empty.

Configuration
REQ-028 Macro POSIT_RESULT_STATS_EN.
- Defined: adds outputs stat_nar[31:0], stat_zero[31:0] and stat_trunc[31:0].
- Each counter increments on every FIFO push whose value is NaR (1 followed by N-1 zeros), zero (all zeros), or has pipe_truncated=1, respectively.
- Each counter saturates at 0xFFFFFFFF and resets to 0.
REQ-029 Macro undefined: none of these ports or counters exist, and all other behaviour is identical.

Verification
REQ-030 Single issue: one accepted issue at cycle 0 with pipe_result=0x40000000 at cycle 12 -> out_valid=1 at cycle 13 with out_data=0x40000000; in_flight is 1 during cycles 1..12 and 0 afterwards.
REQ-031 Back-pressure fill: issue_valid=1 continuously with out_ready=0 -> exactly 16 issues accepted, then issue_ready=0 while in_flight+fifo_count=16; no overflow assertion fires.
REQ-032 Simultaneous push and pop with FIFO at 5 entries and out_ready=1 -> fifo_count stays 5 and order is preserved across a pointer wrap after 20 pops.
REQ-033 Mid-operation reset with 3 in flight and 4 buffered -> out_valid=0 and in_flight=0 immediately; later pipeline data is not captured.
REQ-034 Streaming at full rate: 1000 issues with out_ready=1 -> 1000 outputs in order, matching a reference queue, at one output per cycle after the 13-cycle fill.
REQ-035 With POSIT_RESULT_STATS_EN defined: push 0x80000000, 0x00000000, and 0x12345678 with truncated=1 -> stat_nar=1, stat_zero=1, stat_trunc=1.
